// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Sub-word loads are lane-selected and extended; sub-word stores use read-modify-write.
module mem_access_unit #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_STORE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [DATA_LEN-1:0]   wdata_q, wdata_d;
    logic [DATA_LEN-1:0]   merge_q, merge_d;
    logic [DATA_LEN-1:0]   rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;

    logic                  req_illegal;
    logic                  req_misaligned;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_LEN-1:0]   load_ext;
    logic [DATA_LEN-1:0]   merged;

    // Legality of the request currently presented by the core
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b100, 3'b101:         req_illegal = req_we;
            default:                req_illegal = 1'b0;
        endcase
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Lane selection / extension for loads, lane replacement for sub-word stores
    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_LEN-8){lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{(DATA_LEN-16){lane_h[15]}}, lane_h};
            3'b100:  load_ext = {{(DATA_LEN-8){1'b0}}, lane_b};
            3'b101:  load_ext = {{(DATA_LEN-16){1'b0}}, lane_h};
            default: load_ext = mem_rdata;
        endcase
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        resp_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    if (req_illegal || req_misaligned) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = S_STORE;
                        merge_d = req_wdata;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                state_d = S_RESP;
            end
            S_READ: begin
                merge_d = merged;
                state_d = S_STORE;
            end
            S_STORE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d      = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_read_d   = (state_d == S_LOAD) || (state_d == S_READ);
        mem_write_d  = (state_d == S_STORE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // merge_q holds the full store word for every store, so it feeds memory directly
    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = {addr_q[ADDR_LEN-1:2], 2'b00};
    assign mem_wdata  = merge_q;

    // we_q is retained as part of the latched request for debug visibility
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan items plus randomized
// traffic checked against a byte-array reference model.
module tb_mem_access_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory seen by the DUT; cleared together with the system reset
    logic [31:0] tb_mem [64];
    assign mem_rdata = tb_mem[mem_addr[7:2]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
        end else if (mem_write) begin
            tb_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    logic [7:0] ref_bytes [256];
    int n_cmp, n_fail;

    int          o_lat, o_nrd, o_nwr, o_wcyc;
    logic [31:0] o_rdata, o_waddr, o_wdata;
    logic        o_err, o_both, o_busy_ready, o_idle_ok;

    int          e_lat, e_nrd, e_nwr, e_wcyc;
    logic [31:0] e_rdata, e_waddr, e_wdata;
    logic        e_err;

    // Reference model: byte-addressed memory, sizes and extension by arithmetic
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int     size, a, base;
        logic   legal;
        longint val;
        a     = int'(addr[7:0]);
        legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        size  = 1 << f3[1:0];
        e_rdata = 32'h0; e_waddr = 32'h0; e_wdata = 32'h0;
        e_nrd = 0; e_nwr = 0; e_wcyc = 0; e_err = 1'b0;
        if (!legal || (a % size) != 0) begin
            e_err = 1'b1;
            e_lat = 1;
        end else if (!we) begin
            val = 0;
            for (int i = 0; i < size; i++)
                val = val | (longint'(ref_bytes[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8 * size - 1])
                val = val - (longint'(1) << (8 * size));
            e_rdata = val[31:0];
            e_lat = 2;
            e_nrd = 1;
        end else begin
            for (int i = 0; i < size; i++) ref_bytes[a + i] = wdata[8 * i +: 8];
            base    = a - (a % 4);
            e_wdata = {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
            e_waddr = 32'(base);
            e_nwr   = 1;
            e_nrd   = (size < 4) ? 1 : 0;
            e_lat   = (size < 4) ? 3 : 2;
            e_wcyc  = e_lat - 1;
        end
    endtask

    // Drives one request and records what the DUT did until the response
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        o_lat = -1; o_nrd = 0; o_nwr = 0; o_wcyc = 0;
        o_rdata = 32'hx; o_waddr = 32'h0; o_wdata = 32'h0;
        o_err = 1'bx; o_both = 1'b0; o_busy_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read) o_nrd++;
            if (mem_write) begin
                o_nwr++; o_waddr = mem_addr; o_wdata = mem_wdata; o_wcyc = c;
            end
            if (mem_read && mem_write) o_both = 1'b1;
            if (req_ready) o_busy_ready = 1'b1;
            if (resp_valid) begin
                o_lat = c; o_rdata = resp_rdata; o_err = resp_err;
                break;
            end
        end
        @(negedge clk);
        o_idle_ok = !resp_valid && req_ready && !mem_read && !mem_write;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 10000",
                {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++;
        if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++;
        if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_word();
        model(1'b1, 3'b010, 32'h10, 32'h11223344);
        run_req(1'b1, 3'b010, 32'h10, 32'h11223344);
        n_cmp++;
        if (o_nwr !== 1 || o_nrd !== 0) begin
            n_fail++; $display("FAIL sw_pulses: writes=%0d reads=%0d want 1 0", o_nwr, o_nrd);
        end
        n_cmp++;
        if (o_waddr !== 32'h10) begin n_fail++; $display("FAIL sw_addr: got %h want 00000010", o_waddr); end
        n_cmp++;
        if (o_wdata !== 32'h11223344) begin n_fail++; $display("FAIL sw_wdata: got %h want 11223344", o_wdata); end
        n_cmp++;
        if (o_wcyc !== 1 || o_lat !== 2) begin
            n_fail++; $display("FAIL sw_timing: write_cyc=%0d resp_cyc=%0d want 1 2", o_wcyc, o_lat);
        end
        n_cmp++;
        if (o_err !== 1'b0 || o_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sw_resp: err=%b rdata=%h want 0 00000000", o_err, o_rdata);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3_t [3];
        logic [31:0] a_t  [3];
        logic [31:0] x_t  [3];
        f3_t = '{3'b000, 3'b001, 3'b010};
        a_t  = '{32'h13, 32'h12, 32'h10};
        x_t  = '{32'h00000011, 32'h00001122, 32'h11223344};
        for (int i = 0; i < 3; i++) begin
            model(1'b0, f3_t[i], a_t[i], 32'h0);
            run_req(1'b0, f3_t[i], a_t[i], 32'h0);
            n_cmp++;
            if (o_rdata !== x_t[i] || o_err !== 1'b0) begin
                n_fail++; $display("FAIL load_%0d: rdata=%h err=%b want %h 0", i, o_rdata, o_err, x_t[i]);
            end
            n_cmp++;
            if (o_lat !== 2 || o_nrd !== 1 || o_nwr !== 0) begin
                n_fail++; $display("FAIL load_%0d_timing: resp_cyc=%0d reads=%0d writes=%0d want 2 1 0",
                    i, o_lat, o_nrd, o_nwr);
            end
        end
    endtask

    task automatic test_sub_word();
        logic        we_t [6];
        logic [2:0]  f3_t [6];
        logic [31:0] a_t  [6];
        logic [31:0] d_t  [6];
        logic [31:0] x_t  [6];
        we_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        f3_t = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b101};
        a_t  = '{32'h11, 32'h11, 32'h11, 32'h12, 32'h12, 32'h12};
        d_t  = '{32'h80, 32'h0, 32'h0, 32'hBEEF, 32'h0, 32'h0};
        x_t  = '{32'h11228044, 32'hFFFFFF80, 32'h00000080, 32'hBEEF8044, 32'hFFFFBEEF, 32'h0000BEEF};
        for (int i = 0; i < 6; i++) begin
            model(we_t[i], f3_t[i], a_t[i], d_t[i]);
            run_req(we_t[i], f3_t[i], a_t[i], d_t[i]);
            if (we_t[i]) begin
                n_cmp++;
                if (o_wdata !== x_t[i] || o_waddr !== 32'h10 || o_nwr !== 1) begin
                    n_fail++; $display("FAIL subword_store_%0d: wdata=%h addr=%h writes=%0d want %h 00000010 1",
                        i, o_wdata, o_waddr, o_nwr, x_t[i]);
                end
                n_cmp++;
                if (o_nrd !== 1 || o_wcyc !== 2 || o_lat !== 3) begin
                    n_fail++; $display("FAIL subword_store_%0d_timing: reads=%0d write_cyc=%0d resp_cyc=%0d want 1 2 3",
                        i, o_nrd, o_wcyc, o_lat);
                end
            end else begin
                n_cmp++;
                if (o_rdata !== x_t[i] || o_lat !== 2) begin
                    n_fail++; $display("FAIL subword_load_%0d: rdata=%h resp_cyc=%0d want %h 2",
                        i, o_rdata, o_lat, x_t[i]);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic        we_t [3];
        logic [2:0]  f3_t [3];
        logic [31:0] a_t  [3];
        we_t = '{1'b0, 1'b1, 1'b0};
        f3_t = '{3'b010, 3'b001, 3'b011};
        a_t  = '{32'h12, 32'h13, 32'h10};
        for (int i = 0; i < 3; i++) begin
            model(we_t[i], f3_t[i], a_t[i], 32'hCAFEF00D);
            run_req(we_t[i], f3_t[i], a_t[i], 32'hCAFEF00D);
            n_cmp++;
            if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== 1) begin
                n_fail++; $display("FAIL error_%0d: err=%b rdata=%h resp_cyc=%0d want 1 00000000 1",
                    i, o_err, o_rdata, o_lat);
            end
            n_cmp++;
            if (o_nrd !== 0 || o_nwr !== 0) begin
                n_fail++; $display("FAIL error_%0d_mem: reads=%0d writes=%0d want 0 0", i, o_nrd, o_nwr);
            end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        for (int n = 0; n < 200; n++) begin
            we    = 1'($urandom);
            f3    = 3'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 255));
            wdata = $urandom;
            model(we, f3, addr, wdata);
            run_req(we, f3, addr, wdata);
            n_cmp++;
            if (o_lat !== e_lat || o_err !== e_err || o_rdata !== e_rdata) begin
                n_fail++; $display("FAIL rand_%0d_resp: cyc=%0d err=%b rdata=%h want %0d %b %h (we=%b f3=%b a=%h)",
                    n, o_lat, o_err, o_rdata, e_lat, e_err, e_rdata, we, f3, addr);
            end
            n_cmp++;
            if (o_nrd !== e_nrd || o_nwr !== e_nwr) begin
                n_fail++; $display("FAIL rand_%0d_pulses: reads=%0d writes=%0d want %0d %0d",
                    n, o_nrd, o_nwr, e_nrd, e_nwr);
            end
            if (e_nwr == 1) begin
                n_cmp++;
                if (o_waddr !== e_waddr || o_wdata !== e_wdata || o_wcyc !== e_wcyc) begin
                    n_fail++; $display("FAIL rand_%0d_write: addr=%h data=%h cyc=%0d want %h %h %0d",
                        n, o_waddr, o_wdata, o_wcyc, e_waddr, e_wdata, e_wcyc);
                end
            end
            n_cmp++;
            if (o_both !== 1'b0 || o_busy_ready !== 1'b0 || o_idle_ok !== 1'b1) begin
                n_fail++; $display("FAIL rand_%0d_handshake: rd_wr_overlap=%b ready_busy=%b idle_ok=%b want 0 0 1",
                    n, o_both, o_busy_ready, o_idle_ok);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic stray;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h000000A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL abort_in_read: mem_read=%b mem_write=%b want 1 0", mem_read, mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL abort_outputs: ctrl=%b addr=%h wdata=%h rdata=%h want 10000 0 0 0",
                {req_ready, resp_valid, resp_err, mem_read, mem_write}, mem_addr, mem_wdata, resp_rdata);
        end
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (mem_write || resp_valid) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL abort_stray_activity: got %b want 0", stray); end
        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
        model(1'b0, 3'b010, 32'h10, 32'h0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        n_cmp++;
        if (o_rdata !== 32'h0 || o_rdata !== e_rdata || o_err !== 1'b0 || o_lat !== 2) begin
            n_fail++; $display("FAIL abort_reload: rdata=%h err=%b cyc=%0d want 00000000 0 2", o_rdata, o_err, o_lat);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_store_word();
        test_loads();
        test_sub_word();
        test_errors();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
